// File: rtl/daq_frame_buf_if.sv
// Write/read side signals between the SCA readout, the DAQ link and daq_frame_buf.
interface daq_frame_buf_if;
    logic        PUSH;
    logic [15:0] DIN;
    logic        LASTWORD;
    logic        ERRLOAD;
    logic        RD_EN;
    logic [15:0] DOUT;
    logic        DVALID;
    logic        DEND;
    logic        EVT_AVAIL;
    logic [7:0]  NEVT;
    logic        FULL;
    logic        OVFL;
    logic [7:0]  DROPCNT;

    modport master (
        output PUSH, DIN, LASTWORD, ERRLOAD, RD_EN,
        input  DOUT, DVALID, DEND, EVT_AVAIL, NEVT, FULL, OVFL, DROPCNT
    );

    modport slave (
        input  PUSH, DIN, LASTWORD, ERRLOAD, RD_EN,
        output DOUT, DVALID, DEND, EVT_AVAIL, NEVT, FULL, OVFL, DROPCNT
    );
endinterface

// File: rtl/daq_frame_buf.sv
// Event frame buffer: appends a trailer (and a CRC-16 word when DAQ_FRAME_CRC_EN is defined) and serves only committed events.
// Read latency 1 cycle; no write backpressure -- an event that does not fit is dropped and counted.
module daq_frame_buf #(
    parameter int ADDR_W = 8,
    parameter int TMR    = 0
) (
    input  logic           CLK,
    input  logic           RST,
    daq_frame_buf_if.slave bus
);
    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] FREE_MIN = (ADDR_W + 1)'(3);
    localparam logic [ADDR_W:0] FULL_LIM = (ADDR_W + 1)'(4);

`ifdef DAQ_FRAME_CRC_EN
    typedef enum logic [2:0] {W_IDLE, W_DATA, W_TRL, W_DROP, W_CRC} wstate_t;
`else
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_TRL, W_DROP} wstate_t;
`endif

    wstate_t state, state_nx;

    logic [16:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wptr, sptr, rptr;
    logic [11:0]       wcnt;
    logic              err;
    logic [7:0]        nevt, dropcnt;
    logic              ovfl;
    logic [15:0]       dout;
    logic              dvalid, dend;

    logic [ADDR_W:0]   free;
    logic [15:0]       trailer;
    logic              wr_en, data_acc, commit, drop_done, ovfl_set;
    logic [16:0]       wr_dat;
    logic              rd_grant, rd_mark;
    logic [16:0]       rd_word;

    // Triplication is handled outside this block; the parameter is kept for interface compatibility.
    if (TMR != 0) begin : g_tmr
    end

    assign free    = DEPTH_W - {1'b0, wptr - rptr};
    assign trailer = {4'hE, err, wcnt[10:0]};

`ifdef DAQ_FRAME_CRC_EN
    logic [15:0] crc;

    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= W_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        wr_en     = 1'b0;
        wr_dat    = '0;
        data_acc  = 1'b0;
        commit    = 1'b0;
        drop_done = 1'b0;
        ovfl_set  = 1'b0;
        case (state)
            W_IDLE, W_DATA: begin
                if (bus.PUSH) begin
                    if (free >= FREE_MIN) begin
                        wr_en    = 1'b1;
                        wr_dat   = {1'b0, bus.DIN};
                        data_acc = 1'b1;
                        state_nx = bus.LASTWORD ? W_TRL : W_DATA;
                    end else begin
                        // A last word that cannot fit closes the dropped event immediately.
                        ovfl_set = 1'b1;
                        if (bus.LASTWORD) begin
                            drop_done = 1'b1;
                            state_nx  = W_IDLE;
                        end else begin
                            state_nx  = W_DROP;
                        end
                    end
                end
            end
            W_TRL: begin
                wr_en    = 1'b1;
                ovfl_set = bus.PUSH;
`ifdef DAQ_FRAME_CRC_EN
                wr_dat   = {1'b0, trailer};
                state_nx = W_CRC;
`else
                wr_dat   = {1'b1, trailer};
                commit   = 1'b1;
                state_nx = W_IDLE;
`endif
            end
`ifdef DAQ_FRAME_CRC_EN
            W_CRC: begin
                wr_en    = 1'b1;
                wr_dat   = {1'b1, crc};
                commit   = 1'b1;
                ovfl_set = bus.PUSH;
                state_nx = W_IDLE;
            end
`endif
            W_DROP: begin
                if (bus.PUSH && bus.LASTWORD) begin
                    drop_done = 1'b1;
                    state_nx  = W_IDLE;
                end
            end
            default: state_nx = W_IDLE;
        endcase
    end

    assign rd_grant = bus.RD_EN && (nevt != 8'd0);
    assign rd_word  = mem[rptr];
    assign rd_mark  = rd_grant && rd_word[16];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wptr] <= wr_dat;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr    <= '0;
            sptr    <= '0;
            rptr    <= '0;
            wcnt    <= '0;
            err     <= 1'b0;
            nevt    <= '0;
            dropcnt <= '0;
            ovfl    <= 1'b0;
            dout    <= '0;
            dvalid  <= 1'b0;
            dend    <= 1'b0;
        end else begin
            if (drop_done) begin
                wptr <= sptr;
            end else if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (commit) begin
                sptr <= wptr + 1'b1;
            end
            if (commit || drop_done) begin
                wcnt <= '0;
                err  <= 1'b0;
            end else begin
                if (data_acc) begin
                    wcnt <= wcnt + 1'b1;
                end
                if (bus.PUSH && bus.ERRLOAD) begin
                    err <= 1'b1;
                end
            end
            if (ovfl_set) begin
                ovfl <= 1'b1;
            end
            if (drop_done && dropcnt != 8'hFF) begin
                dropcnt <= dropcnt + 1'b1;
            end
            // A commit and a trailer read in the same cycle cancel out.
            case ({commit, rd_mark})
                2'b10:   nevt <= nevt + 1'b1;
                2'b01:   nevt <= nevt - 1'b1;
                default: nevt <= nevt;
            endcase
            dvalid <= rd_grant;
            dend   <= rd_mark;
            if (rd_grant) begin
                dout <= rd_word[15:0];
                rptr <= rptr + 1'b1;
            end
        end
    end

`ifdef DAQ_FRAME_CRC_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            crc <= 16'hFFFF;
        end else if (commit || drop_done) begin
            crc <= 16'hFFFF;
        end else if (data_acc) begin
            crc <= crc16_upd(crc, bus.DIN);
        end else if (state == W_TRL) begin
            crc <= crc16_upd(crc, trailer);
        end
    end
`endif

    assign bus.DOUT      = dout;
    assign bus.DVALID    = dvalid;
    assign bus.DEND      = dend;
    assign bus.NEVT      = nevt;
    assign bus.EVT_AVAIL = (nevt != 8'd0);
    assign bus.FULL      = (free < FULL_LIM);
    assign bus.OVFL      = ovfl;
    assign bus.DROPCNT   = dropcnt;
endmodule

// File: tb/tb_daq_frame_buf.sv
// Bench for daq_frame_buf (ADDR_W=4): queue-based event model, per-cycle compare, directed and random traffic.
module tb_daq_frame_buf;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    daq_frame_buf_if bus ();

    daq_frame_buf #(.ADDR_W(AW), .TMR(0)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: committed words awaiting read, and words of the open event.
    logic [16:0] cq[$];
    logic [15:0] oq[$];
    bit          m_err, m_trl, m_dropping, m_ovfl, m_dvalid, m_dend;
    int          m_nevt, m_dropcnt;
    logic [15:0] m_dout;
    logic [16:0] cap[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        cq.delete();
        oq.delete();
        m_err = 0; m_trl = 0; m_dropping = 0; m_ovfl = 0;
        m_dvalid = 0; m_dend = 0; m_nevt = 0; m_dropcnt = 0; m_dout = '0;
    endfunction

    function automatic void model_step(bit p, logic [15:0] d, bit l, bit e, bit r);
        int free;
        logic [16:0] w;
        free = DEPTH - (cq.size() + oq.size());
        m_dvalid = 0;
        m_dend   = 0;
        if (r && m_nevt != 0) begin
            w = cq.pop_front();
            m_dvalid = 1;
            m_dout   = w[15:0];
            m_dend   = w[16];
            if (w[16]) m_nevt--;
        end
        if (m_trl) begin
            foreach (oq[i]) cq.push_back({1'b0, oq[i]});
            cq.push_back({1'b1, 4'hE, m_err, 11'(oq.size())});
            oq.delete();
            m_nevt++;
            m_trl = 0;
            m_err = 0;
            if (p) m_ovfl = 1;
        end else if (m_dropping) begin
            if (p && l) begin
                m_dropping = 0;
                oq.delete();
                m_err = 0;
                if (m_dropcnt < 255) m_dropcnt++;
            end
        end else if (p) begin
            if (free >= 3) begin
                oq.push_back(d);
                m_err = m_err | e;
                if (l) m_trl = 1;
            end else begin
                m_ovfl = 1;
                if (l) begin
                    oq.delete();
                    m_err = 0;
                    if (m_dropcnt < 255) m_dropcnt++;
                end else begin
                    m_dropping = 1;
                end
            end
        end
    endfunction

    task automatic cyc(input bit p, input logic [15:0] d, input bit l, input bit e, input bit r);
        bus.PUSH = p; bus.DIN = d; bus.LASTWORD = l; bus.ERRLOAD = e; bus.RD_EN = r;
        @(posedge CLK);
        if (RST) model_reset();
        else     model_step(p, d, l, e, r);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 16'h0, 0, 0, 0);
    endtask

    task automatic rd(input int n);
        for (int i = 0; i < n; i++) cyc(0, 16'h0, 0, 0, 1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle(2);
        RST = 1'b0;
    endtask

    task automatic check_cap(input string name, input int idx, input logic [16:0] exp);
        if (idx < cap.size()) check(name, 32'(cap[idx]), 32'(exp));
        else                  check(name, 32'hDEAD_BEEF, 32'(exp));
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("dvalid", 32'(bus.DVALID), 32'(m_dvalid));
            check("dend", 32'(bus.DEND), 32'(m_dend));
            if (m_dvalid) check("dout", 32'(bus.DOUT), 32'(m_dout));
            check("nevt", 32'(bus.NEVT), 32'(m_nevt));
            check("evt_avail", 32'(bus.EVT_AVAIL), 32'(m_nevt != 0));
            check("full", 32'(bus.FULL), 32'((DEPTH - (cq.size() + oq.size())) < 4));
            check("ovfl", 32'(bus.OVFL), 32'(m_ovfl));
            check("dropcnt", 32'(bus.DROPCNT), 32'(m_dropcnt));
            if (bus.DVALID === 1'b1) cap.push_back({bus.DEND, bus.DOUT});
        end
    end

    initial begin
        int rdpct;
        bit p, l, e, r;
        bus.PUSH = 0; bus.DIN = '0; bus.LASTWORD = 0; bus.ERRLOAD = 0; bus.RD_EN = 0;
        do_reset();
        chk_en = 1'b1;
        check("rst_nevt", 32'(bus.NEVT), 32'd0);
        check("rst_dvalid", 32'(bus.DVALID), 32'd0);
        check("rst_ovfl", 32'(bus.OVFL), 32'd0);
        check("rst_dropcnt", 32'(bus.DROPCNT), 32'd0);
        check("rst_full", 32'(bus.FULL), 32'd0);
        check("rst_evt_avail", 32'(bus.EVT_AVAIL), 32'd0);

        // Basic three-word event
        cap.delete();
        cyc(1, 16'h1001, 0, 0, 0);
        cyc(1, 16'h1002, 0, 0, 0);
        cyc(1, 16'h1003, 1, 0, 0);
        idle(1);
        check("basic_nevt_before", 32'(bus.NEVT), 32'd1);
        rd(4);
        idle(1);
        check("basic_len", 32'(cap.size()), 32'd4);
        check_cap("basic_w0", 0, {1'b0, 16'h1001});
        check_cap("basic_w1", 1, {1'b0, 16'h1002});
        check_cap("basic_w2", 2, {1'b0, 16'h1003});
        check_cap("basic_trl", 3, {1'b1, 16'hE003});
        check("basic_nevt_after", 32'(bus.NEVT), 32'd0);

        // Error flag on the second word
        cap.delete();
        cyc(1, 16'h2001, 0, 0, 0);
        cyc(1, 16'h2002, 0, 1, 0);
        cyc(1, 16'h2003, 1, 0, 0);
        idle(1);
        rd(4);
        idle(1);
        check_cap("err_trl", 3, {1'b1, 16'hE803});

        // Oversized event is dropped, next event survives
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1, 16'(16'h4000 + i), (i == 19), 0, 0);
        idle(1);
        check("drop_ovfl", 32'(bus.OVFL), 32'd1);
        check("drop_cnt", 32'(bus.DROPCNT), 32'd1);
        check("drop_nevt", 32'(bus.NEVT), 32'd0);
        check("drop_wptr_restored", 32'(bus.FULL), 32'd0);
        cap.delete();
        cyc(1, 16'hA001, 0, 0, 0);
        cyc(1, 16'hA002, 1, 0, 0);
        idle(1);
        rd(3);
        idle(1);
        check_cap("after_drop_w0", 0, {1'b0, 16'hA001});
        check_cap("after_drop_w1", 1, {1'b0, 16'hA002});
        check_cap("after_drop_trl", 2, {1'b1, 16'hE002});

        // Push during trailer cycle
        do_reset();
        cap.delete();
        cyc(1, 16'h3001, 0, 0, 0);
        cyc(1, 16'h3002, 1, 0, 0);
        cyc(1, 16'hDEAD, 0, 0, 0);
        idle(1);
        check("trlpush_ovfl", 32'(bus.OVFL), 32'd1);
        check("trlpush_nevt", 32'(bus.NEVT), 32'd1);
        rd(3);
        idle(1);
        check_cap("trlpush_trl", 2, {1'b1, 16'hE002});
        check("trlpush_len", 32'(cap.size()), 32'd3);

        // Commit of B coinciding with read of A's trailer
        do_reset();
        cap.delete();
        cyc(1, 16'h0011, 1, 0, 0);
        idle(1);
        cyc(1, 16'h0021, 0, 0, 0);
        cyc(1, 16'h0022, 1, 0, 1);
        cyc(0, 16'h0, 0, 0, 1);
        check("same_cycle_nevt", 32'(bus.NEVT), 32'd1);
        rd(3);
        idle(1);
        check_cap("same_cycle_a_trl", 1, {1'b1, 16'hE001});
        check_cap("same_cycle_b_trl", 4, {1'b1, 16'hE002});

        // Random traffic with varying read pressure; the small buffer wraps constantly
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            rdpct = (ph == 0) ? 15 : ((ph == 1) ? 50 : 90);
            for (int i = 0; i < 3000; i++) begin
                p = ($urandom_range(99) < 60);
                l = ($urandom_range(5) == 0);
                e = ($urandom_range(7) == 0);
                r = ($urandom_range(99) < rdpct);
                cyc(p, 16'($urandom), l, e, r);
            end
        end
        for (int i = 0; i < 300 && m_nevt != 0; i++) rd(1);
        idle(1);
        check("drain_nevt", 32'(bus.NEVT), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
